// File: rtl/pkt_flow_stats.sv
// Per-flow packet and byte statistics collected from a 64-bit sop/eop beat stream.
// Framing errors are counted in err_cnt_o; counters are readable one cycle after a request.
module pkt_flow_stats #(
  parameter int unsigned FLOW_CNT       = 16,
  parameter int unsigned FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int unsigned PKT_CNT_WIDTH  = 32,
  parameter int unsigned BYTE_CNT_WIDTH = 48
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [63:0]               pkt_data_i,
  input  logic                      pkt_sop_i,
  input  logic                      pkt_eop_i,
  input  logic [2:0]                pkt_empty_i,
  input  logic [FLOW_CNT_WIDTH-1:0] pkt_flow_num_i,
  input  logic                      pkt_valid_i,
  output logic                      pkt_ready_o,
  input  logic [FLOW_CNT_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_req_i,
  output logic [PKT_CNT_WIDTH-1:0]  rd_pkt_cnt_o,
  output logic [BYTE_CNT_WIDTH-1:0] rd_byte_cnt_o,
  output logic                      rd_valid_o,
  input  logic                      clr_all_i,
  output logic [15:0]               err_cnt_o
);

  localparam int unsigned SumW = ((BYTE_CNT_WIDTH > 16) ? BYTE_CNT_WIDTH : 16) + 1;
  localparam logic [FLOW_CNT_WIDTH:0] FlowLimit = FLOW_CNT[FLOW_CNT_WIDTH:0];
  localparam logic [SumW-1:0] ByteMax =
      {{(SumW - BYTE_CNT_WIDTH){1'b0}}, {BYTE_CNT_WIDTH{1'b1}}};

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e state_q, state_d;

  logic                      beat_acc;
  logic                      pkt_start, pkt_beat, pkt_end, err_drop, err_restart;
  logic [15:0]               acc_q, acc_d, acc_inc, end_len;
  logic [16:0]               acc_sum;
  logic [FLOW_CNT_WIDTH-1:0] flow_q, flow_d;
  logic                      flow_ok;

  logic                      upd_vld_q;
  logic [FLOW_CNT_WIDTH-1:0] upd_flow_q;
  logic [15:0]               upd_len_q;

  logic [PKT_CNT_WIDTH-1:0]  pkt_cnt_q  [FLOW_CNT];
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q [FLOW_CNT];
  logic [PKT_CNT_WIDTH:0]    pkt_sum;
  logic [PKT_CNT_WIDTH-1:0]  pkt_inc;
  logic [SumW-1:0]           byte_sum;
  logic [BYTE_CNT_WIDTH-1:0] byte_inc;

  logic [1:0]                err_inc;
  logic [16:0]               err_sum;
  logic [15:0]               err_q;

  logic                      rd_valid_q;
  logic [PKT_CNT_WIDTH-1:0]  rd_pkt_q;
  logic [BYTE_CNT_WIDTH-1:0] rd_byte_q;
  logic                      rd_addr_ok;

  logic unused_data;
  assign unused_data = ^pkt_data_i;

  // Ready is only withheld while reset is applied, so it rises in the first cycle after it.
  assign pkt_ready_o = ~rst_i;
  assign beat_acc    = pkt_valid_i & pkt_ready_o;

  // Framing FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM: next state
  always_comb begin
    state_d = state_q;
    if (beat_acc) begin
      unique case (state_q)
        StIdle:  if (pkt_sop_i && !pkt_eop_i) state_d = StInPkt;
        StInPkt: if (pkt_eop_i) state_d = StIdle;
      endcase
    end
  end

  // Framing FSM: per-beat events
  always_comb begin
    pkt_start   = 1'b0;
    pkt_beat    = 1'b0;
    pkt_end     = 1'b0;
    err_drop    = 1'b0;
    err_restart = 1'b0;
    if (beat_acc) begin
      unique case (state_q)
        StIdle: begin
          pkt_start = pkt_sop_i;
          pkt_end   = pkt_sop_i & pkt_eop_i;
          err_drop  = ~pkt_sop_i;
        end
        StInPkt: begin
          pkt_start   = pkt_sop_i;
          pkt_beat    = ~pkt_sop_i;
          pkt_end     = pkt_eop_i;
          err_restart = pkt_sop_i;
        end
      endcase
    end
  end

  always_comb begin
    acc_sum = {1'b0, acc_q} + 17'd8;
    acc_inc = acc_sum[16] ? 16'hffff : acc_sum[15:0];
    acc_d   = pkt_start ? 16'd8 : (pkt_beat ? acc_inc : acc_q);
    end_len = acc_d - {13'd0, pkt_empty_i};
    flow_d  = pkt_start ? pkt_flow_num_i : flow_q;
    flow_ok = {1'b0, flow_d} < FlowLimit;
    err_inc = {1'b0, err_drop} + {1'b0, err_restart} + {1'b0, pkt_end & ~flow_ok};
    err_sum = {1'b0, err_q} + {15'd0, err_inc};
  end

  // Completed packets land in the counters one cycle after their eop beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      flow_q     <= '0;
      upd_vld_q  <= 1'b0;
      upd_flow_q <= '0;
      upd_len_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      flow_q     <= flow_d;
      upd_vld_q  <= pkt_end & flow_ok;
      upd_flow_q <= flow_d;
      upd_len_q  <= end_len;
    end
  end

  always_comb begin
    pkt_sum  = {1'b0, pkt_cnt_q[upd_flow_q]} + {{PKT_CNT_WIDTH{1'b0}}, 1'b1};
    pkt_inc  = pkt_sum[PKT_CNT_WIDTH] ? {PKT_CNT_WIDTH{1'b1}} : pkt_sum[PKT_CNT_WIDTH-1:0];
    byte_sum = {{(SumW - BYTE_CNT_WIDTH){1'b0}}, byte_cnt_q[upd_flow_q]}
             + {{(SumW - 16){1'b0}}, upd_len_q};
    byte_inc = (byte_sum > ByteMax) ? {BYTE_CNT_WIDTH{1'b1}} : byte_sum[BYTE_CNT_WIDTH-1:0];
  end

  // A clear in the landing cycle wins over the pending update.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_all_i) begin
      for (int i = 0; i < int'(FLOW_CNT); i++) begin
        pkt_cnt_q[i]  <= '0;
        byte_cnt_q[i] <= '0;
      end
    end else if (upd_vld_q) begin
      pkt_cnt_q[upd_flow_q]  <= pkt_inc;
      byte_cnt_q[upd_flow_q] <= byte_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_all_i) begin
      err_q <= '0;
    end else begin
      err_q <= err_sum[16] ? 16'hffff : err_sum[15:0];
    end
  end

  assign rd_addr_ok = {1'b0, rd_addr_i} < FlowLimit;

  // Read data is sampled before this edge's counter update, giving pre-update values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_pkt_q   <= '0;
      rd_byte_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) begin
        rd_pkt_q  <= rd_addr_ok ? pkt_cnt_q[rd_addr_i] : '0;
        rd_byte_q <= rd_addr_ok ? byte_cnt_q[rd_addr_i] : '0;
      end
    end
  end

  assign rd_valid_o    = rd_valid_q;
  assign rd_pkt_cnt_o  = rd_pkt_q;
  assign rd_byte_cnt_o = rd_byte_q;
  assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_pkt_flow_stats.sv
// Bench for pkt_flow_stats: a directed vector table, hand-written corner sequences and
// random traffic, all checked every cycle against a packet-level reference model.
module tb_pkt_flow_stats;

  localparam int FC = 6;
  localparam int FW = 3;
  localparam int PW = 4;
  localparam int BW = 10;
  localparam int PMAX = (1 << PW) - 1;
  localparam int BMAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   data = '0;
  logic          sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic [2:0]    empty = '0;
  logic [FW-1:0] flow = '0, rd_addr = '0;
  logic          rd_req = 1'b0, clr = 1'b0;
  logic          pkt_ready_o, rd_valid_o;
  logic [PW-1:0] rd_pkt_cnt_o;
  logic [BW-1:0] rd_byte_cnt_o;
  logic [15:0]   err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pkt_flow_stats #(
    .FLOW_CNT      (FC),
    .PKT_CNT_WIDTH (PW),
    .BYTE_CNT_WIDTH(BW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pkt_data_i    (data),
    .pkt_sop_i     (sop),
    .pkt_eop_i     (eop),
    .pkt_empty_i   (empty),
    .pkt_flow_num_i(flow),
    .pkt_valid_i   (valid),
    .pkt_ready_o   (pkt_ready_o),
    .rd_addr_i     (rd_addr),
    .rd_req_i      (rd_req),
    .rd_pkt_cnt_o  (rd_pkt_cnt_o),
    .rd_byte_cnt_o (rd_byte_cnt_o),
    .rd_valid_o    (rd_valid_o),
    .clr_all_i     (clr),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: whole-packet view (beat count, pending completion, saturating totals).
  int m_pkt[8], m_byte[8], m_err;
  bit m_open, m_pend, e_rdv;
  int m_flow, m_beats, m_pflow, m_plen, e_rdp, e_rdb;

  task automatic model_edge();
    int errs, len;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_pkt[i] = 0; m_byte[i] = 0; end
      m_err = 0; m_open = 0; m_pend = 0; e_rdv = 0; e_rdp = 0; e_rdb = 0;
    end else begin
      e_rdv = rd_req;
      if (rd_req) begin
        e_rdp = (int'(rd_addr) < FC) ? m_pkt[rd_addr] : 0;
        e_rdb = (int'(rd_addr) < FC) ? m_byte[rd_addr] : 0;
      end
      if (clr) begin
        for (int i = 0; i < 8; i++) begin m_pkt[i] = 0; m_byte[i] = 0; end
      end else if (m_pend) begin
        m_pkt[m_pflow]  = (m_pkt[m_pflow] + 1 > PMAX) ? PMAX : m_pkt[m_pflow] + 1;
        m_byte[m_pflow] = (m_byte[m_pflow] + m_plen > BMAX) ? BMAX : m_byte[m_pflow] + m_plen;
      end
      m_pend = 0;
      errs = 0;
      if (valid) begin
        if (sop) begin
          if (m_open) errs++;
          m_open = 1; m_flow = int'(flow); m_beats = 1;
        end else if (!m_open) begin
          errs++;
        end else begin
          m_beats++;
        end
        if (m_open && eop) begin
          m_open = 0;
          len = ((m_beats * 8 > 65535) ? 65535 : m_beats * 8) - int'(empty);
          if (m_flow < FC) begin m_pend = 1; m_pflow = m_flow; m_plen = len; end
          else errs++;
        end
      end
      m_err = clr ? 0 : ((m_err + errs > 65535) ? 65535 : m_err + errs);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("ready", 64'(pkt_ready_o), 64'(!rst));
    chk("rd_valid", 64'(rd_valid_o), 64'(e_rdv));
    chk("rd_pkt", 64'(rd_pkt_cnt_o), 64'(e_rdp));
    chk("rd_byte", 64'(rd_byte_cnt_o), 64'(e_rdb));
    chk("err", 64'(err_cnt_o), 64'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic s, input logic e, input logic [2:0] emp, input logic [FW-1:0] f);
    valid = 1'b1; sop = s; eop = e; empty = emp; flow = f; data = {$urandom, $urandom};
    step();
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic pkt(input logic [FW-1:0] f, input int beats, input logic [2:0] emp);
    for (int b = 0; b < beats; b++) send(b == 0, b == beats - 1, emp, f);
  endtask

  task automatic rd_chk(input string nm, input logic [FW-1:0] a, input int ep, input int eb);
    rd_req = 1'b1; rd_addr = a;
    step();
    rd_req = 1'b0;
    chk({nm, "_valid"}, 64'(rd_valid_o), 64'd1);
    chk({nm, "_pkt"}, 64'(rd_pkt_cnt_o), 64'(ep));
    chk({nm, "_byte"}, 64'(rd_byte_cnt_o), 64'(eb));
  endtask

  typedef struct {
    logic rst, vld, sop, eop; logic [2:0] empty, flow; logic rd; logic [2:0] addr; logic clr;
    logic e_rdv; logic [3:0] e_pkt; logic [9:0] e_byte; logic [15:0] e_err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // rst vld sop eop emp flow rd addr clr | rdv pkt byte err
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 27, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 27, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 27, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 1, 6, 0, 1, 0, 0, 2};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 1, 27, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; valid = tbl[i].vld; sop = tbl[i].sop; eop = tbl[i].eop;
      empty = tbl[i].empty; flow = tbl[i].flow; rd_req = tbl[i].rd; rd_addr = tbl[i].addr;
      clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_rdv", i), 64'(rd_valid_o), 64'(tbl[i].e_rdv));
      chk($sformatf("tbl%0d_pkt", i), 64'(rd_pkt_cnt_o), 64'(tbl[i].e_pkt));
      chk($sformatf("tbl%0d_byte", i), 64'(rd_byte_cnt_o), 64'(tbl[i].e_byte));
      chk($sformatf("tbl%0d_err", i), 64'(err_cnt_o), 64'(tbl[i].e_err));
    end
    rst = 0; valid = 0; sop = 0; eop = 0; rd_req = 0; clr = 0;

    // Ten back-to-back single-beat packets on flow 0
    do_reset();
    for (int i = 0; i < 10; i++) send(1, 1, 0, 0);
    idle(1);
    rd_chk("b2b_flow0", 0, 10, 80);
    chk("b2b_err", 64'(err_cnt_o), 64'd0);

    // Back-to-back eops alternating flows
    do_reset();
    send(1, 1, 1, 1); send(1, 1, 2, 2); send(1, 1, 0, 1);
    idle(1);
    rd_chk("alt_flow1", 1, 2, 15);
    rd_chk("alt_flow2", 2, 1, 6);

    // Restart: open flow 2 packet abandoned by a sop on flow 5
    do_reset();
    send(1, 0, 0, 2); send(0, 0, 0, 0); send(1, 0, 0, 5); send(0, 0, 0, 0); send(0, 1, 3, 0);
    idle(1);
    rd_chk("restart_flow2", 2, 0, 0);
    rd_chk("restart_flow5", 5, 1, 21);
    chk("restart_err", 64'(err_cnt_o), 64'd1);

    // Read in the landing cycle returns the old value
    do_reset();
    send(1, 1, 0, 1);
    rd_chk("land_old", 1, 0, 0);
    rd_chk("land_new", 1, 1, 8);

    // Packet counter saturation, then byte counter saturation
    do_reset();
    for (int i = 0; i < 15; i++) send(1, 1, 0, 0);
    idle(1);
    rd_chk("pkt_full", 0, 15, 120);
    send(1, 1, 0, 0);
    idle(1);
    rd_chk("pkt_sat", 0, 15, 128);
    for (int i = 0; i < 9; i++) pkt(1, 16, 0);
    idle(1);
    rd_chk("byte_sat", 1, 9, BMAX);

    // Clear coincident with an update to flow 4
    do_reset();
    send(1, 1, 0, 4);
    clr = 1'b1; step(); clr = 1'b0;
    rd_chk("clr_win", 4, 0, 0);

    // Clear mid-packet leaves framing intact
    send(1, 0, 0, 3);
    clr = 1'b1; send(0, 0, 0, 0); clr = 1'b0;
    send(0, 1, 0, 0);
    idle(1);
    rd_chk("clr_mid", 3, 1, 24);

    // Reset mid-packet drops it; the stray eop afterwards is an error
    do_reset();
    send(1, 0, 0, 2); send(0, 0, 0, 0);
    do_reset();
    send(0, 1, 0, 0);
    pkt(2, 2, 3);
    idle(1);
    rd_chk("rst_mid", 2, 1, 13);
    chk("rst_mid_err", 64'(err_cnt_o), 64'd1);

    // Out-of-range flows
    do_reset();
    pkt(6, 2, 0); pkt(7, 1, 0);
    idle(1);
    rd_chk("bad_flow6", 6, 0, 0);
    chk("bad_flow_err", 64'(err_cnt_o), 64'd2);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      valid  = ($urandom_range(0, 9) < 7);
      sop    = ($urandom_range(0, 3) == 0);
      eop    = ($urandom_range(0, 3) == 0);
      empty  = 3'($urandom_range(0, 7));
      flow   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rd_req = ($urandom_range(0, 9) < 3);
      rd_addr = 3'($urandom_range(0, 7));
      clr    = ($urandom_range(0, 99) == 0);
      data   = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
